// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane count.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam int NUM_LANES = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_R,
      RESP,
      ERR
   } state_t;

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request/response and data-memory port bundle of the LSU.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_misalign_o;
   logic              stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [3:0]        mem_be_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, addr_i, wdata_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o, stall_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, addr_i, wdata_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misalign_o, stall_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: enables, store replication, misalign check, load shift/extend.
// Purely combinational; no state, no backpressure.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]           size,
   input  logic                 is_unsigned,
   input  logic [1:0]           addr_lo,
   input  logic [1:0]           chk_size,
   input  logic [1:0]           chk_addr_lo,
   input  logic [DATA_W-1:0]    wdata,
   input  logic [DATA_W-1:0]    rdata,
   output logic [NUM_LANES-1:0] be,
   output logic [DATA_W-1:0]    wdata_rep,
   output logic                 misalign,
   output logic [DATA_W-1:0]    rdata_ext
);
   logic [DATA_W-1:0] sh;

   always_comb begin
      be        = '0;
      wdata_rep = wdata;
      rdata_ext = '0;
      sh        = rdata >> {addr_lo, 3'b000};
      misalign  = (chk_size == 2'd3) ||
                  (chk_size == SZ_H && chk_addr_lo[0]) ||
                  (chk_size == SZ_W && chk_addr_lo != 2'b00);
      case (size)
         SZ_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
         end
         SZ_H: begin
            be        = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
         end
         default: begin
            be        = 4'b1111;
            rdata_ext = sh;
         end
      endcase
   end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time over a req/gnt/rvalid memory port.
// Latency from accept: load 3, store 2, misaligned 1 cycle; stalls while busy.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic  clk,
   input logic  rst_n,
   lsu_if.slave bus
);
   state_t              state, state_nxt;
   logic                we_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [NUM_LANES-1:0] be;
   logic [DATA_W-1:0]   wdata_rep;
   logic [DATA_W-1:0]   rdata_ext;
   logic                misalign;
   logic                in_req;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .size        (size_q),
      .is_unsigned (uns_q),
      .addr_lo     (addr_q[1:0]),
      .chk_size    (bus.req_size_i),
      .chk_addr_lo (bus.addr_i[1:0]),
      .wdata       (wdata_q),
      .rdata       (bus.mem_rdata_i),
      .be          (be),
      .wdata_rep   (wdata_rep),
      .misalign    (misalign),
      .rdata_ext   (rdata_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid_i) state_nxt = misalign ? ERR : REQ;
         REQ:     if (bus.mem_gnt_i)   state_nxt = we_q ? RESP : WAIT_R;
         WAIT_R:  if (bus.mem_rvalid_i) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Accept clears the load result so stores and rejected accesses return 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            size_q  <= bus.req_size_i;
            uns_q   <= bus.req_unsigned_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
            rdata_q <= '0;
         end
         if (state == WAIT_R && bus.mem_rvalid_i) rdata_q <= rdata_ext;
      end
   end

   // Memory fields are gated so they read 0 outside an active request.
   assign in_req             = (state == REQ);
   assign bus.mem_req_o      = in_req;
   assign bus.mem_we_o       = in_req & we_q;
   assign bus.mem_be_o       = in_req ? be : '0;
   assign bus.mem_addr_o     = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.mem_wdata_o    = in_req ? wdata_rep : '0;
   assign bus.req_ready_o    = (state == IDLE);
   assign bus.stall_o        = (state != IDLE);
   assign bus.rsp_valid_o    = (state == RESP) || (state == ERR);
   assign bus.rsp_misalign_o = (state == ERR);
   assign bus.rsp_rdata_o    = rdata_q;
endmodule
